core_ex_wbck: RTL and testbench

Write-back stage of the student core. It collects completed results from the single-cycle ALU and the long-latency LSU and arbitrates them onto the single register-file write port. It registers the winner for one cycle and drives `wb_dest_wen`/`wb_dest_idx`/`wb_dest_dat` into the execute-stage register file. The same registered value is exposed as a bypass source for operand read.

---
 rtl/core_ex_wbck_pkg.sv | 18 +
 rtl/core_ex_wbck_if.sv | 42 ++++
 rtl/core_ex_wbck_arb.sv | 45 ++++
 rtl/core_ex_wbck.sv | 61 ++++++
 tb/tb_core_ex_wbck.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/core_ex_wbck_pkg.sv
// Shared constants for the write-back stage: core widths, starvation limit and
// grant bit positions used by the arbiter and the wb register.
package core_ex_wbck_pkg;

  localparam int CORE_XLEN            = 32;
  localparam int CORE_RFIDX_WIDTH     = 5;
  localparam int CORE_WBCK_STARVE_LIM = 4;

  // one-hot grant bit positions
  localparam int GNT_ALU = 0;
  localparam int GNT_LSU = 1;

  // counter must be able to hold STARVE_LIM itself
  function automatic int starve_cnt_w(input int lim);
    return (lim < 1) ? 1 : $clog2(lim + 1);
  endfunction

endpackage

// File: rtl/core_ex_wbck_if.sv
// Write-back bundle: ALU/LSU result handshakes in, register-file write and
// bypass out. Slave is the write-back stage, master the surrounding core.
interface core_ex_wbck_if
  import core_ex_wbck_pkg::*;
#(
  parameter int XLEN        = CORE_XLEN,
  parameter int RFIDX_WIDTH = CORE_RFIDX_WIDTH
);
  logic                   alu_wbck_valid;
  logic                   alu_wbck_ready;
  logic [RFIDX_WIDTH-1:0] alu_wbck_idx;
  logic [XLEN-1:0]        alu_wbck_dat;

  logic                   lsu_wbck_valid;
  logic                   lsu_wbck_ready;
  logic [RFIDX_WIDTH-1:0] lsu_wbck_idx;
  logic [XLEN-1:0]        lsu_wbck_dat;

  logic                   wb_dest_wen;
  logic [RFIDX_WIDTH-1:0] wb_dest_idx;
  logic [XLEN-1:0]        wb_dest_dat;

  logic                   fwd_valid;
  logic [RFIDX_WIDTH-1:0] fwd_idx;
  logic [XLEN-1:0]        fwd_dat;

  modport slave (
    input  alu_wbck_valid, alu_wbck_idx, alu_wbck_dat,
    input  lsu_wbck_valid, lsu_wbck_idx, lsu_wbck_dat,
    output alu_wbck_ready, lsu_wbck_ready,
    output wb_dest_wen, wb_dest_idx, wb_dest_dat,
    output fwd_valid, fwd_idx, fwd_dat
  );

  modport master (
    output alu_wbck_valid, alu_wbck_idx, alu_wbck_dat,
    output lsu_wbck_valid, lsu_wbck_idx, lsu_wbck_dat,
    input  alu_wbck_ready, lsu_wbck_ready,
    input  wb_dest_wen, wb_dest_idx, wb_dest_dat,
    input  fwd_valid, fwd_idx, fwd_dat
  );
endinterface

// File: rtl/core_ex_wbck_arb.sv
// Two-source write-back arbiter: LSU wins contested cycles until it has won
// STARVE_LIM in a row, then the ALU is forced through once.
module core_wbck_arb
  import core_ex_wbck_pkg::*;
#(
  parameter int STARVE_LIM = CORE_WBCK_STARVE_LIM
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       alu_valid_i,
  input  logic       lsu_valid_i,
  output logic       alu_ready_o,
  output logic       lsu_ready_o,
  output logic [1:0] grant_o
);
  localparam int CNT_W = starve_cnt_w(STARVE_LIM);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             contested;
  logic             force_alu;

  assign contested = alu_valid_i & lsu_valid_i;
  assign force_alu = (starve_cnt_q == CNT_W'(STARVE_LIM));

  // readys depend only on valids and counter, never on source data
  assign alu_ready_o = ~lsu_valid_i | force_alu;
  assign lsu_ready_o = ~alu_valid_i | ~force_alu;

  assign grant_o[GNT_ALU] = alu_valid_i & alu_ready_o;
  assign grant_o[GNT_LSU] = lsu_valid_i & lsu_ready_o;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!alu_valid_i)
      starve_cnt_d = '0;
    else if (contested)
      starve_cnt_d = force_alu ? '0 : starve_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) starve_cnt_q <= '0;
    else     starve_cnt_q <= starve_cnt_d;
  end

endmodule

// File: rtl/core_ex_wbck.sv
// Write-back stage: arbitrates ALU/LSU results onto the single RF write port
// and registers the winner; the same register doubles as the bypass entry.
module core_ex_wbck
  import core_ex_wbck_pkg::*;
#(
  parameter int XLEN        = CORE_XLEN,
  parameter int RFIDX_WIDTH = CORE_RFIDX_WIDTH,
  parameter int STARVE_LIM  = CORE_WBCK_STARVE_LIM
) (
  input  logic                 clk,
  input  logic                 rst,
  core_ex_wbck_if.slave        wb
);
  logic [1:0]             grant;
  logic                   xfer;
  logic [RFIDX_WIDTH-1:0] win_idx;
  logic [XLEN-1:0]        win_dat;

  logic                   wen_q, wen_d;
  logic [RFIDX_WIDTH-1:0] idx_q, idx_d;
  logic [XLEN-1:0]        dat_q, dat_d;

  core_wbck_arb #(.STARVE_LIM(STARVE_LIM)) u_arb (
    .clk         (clk),
    .rst         (rst),
    .alu_valid_i (wb.alu_wbck_valid),
    .lsu_valid_i (wb.lsu_wbck_valid),
    .alu_ready_o (wb.alu_wbck_ready),
    .lsu_ready_o (wb.lsu_wbck_ready),
    .grant_o     (grant)
  );

  assign xfer    = |grant;
  assign win_idx = grant[GNT_LSU] ? wb.lsu_wbck_idx : wb.alu_wbck_idx;
  assign win_dat = grant[GNT_LSU] ? wb.lsu_wbck_dat : wb.alu_wbck_dat;

  // x0 still handshakes but must never produce a write or a bypass hit
  assign wen_d = xfer & (win_idx != '0);
  assign idx_d = xfer ? win_idx : idx_q;
  assign dat_d = xfer ? win_dat : dat_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wen_q <= 1'b0;
      idx_q <= '0;
      dat_q <= '0;
    end else begin
      wen_q <= wen_d;
      idx_q <= idx_d;
      dat_q <= dat_d;
    end
  end

  assign wb.wb_dest_wen = wen_q;
  assign wb.wb_dest_idx = idx_q;
  assign wb.wb_dest_dat = dat_q;
  assign wb.fwd_valid   = wen_q;
  assign wb.fwd_idx     = idx_q;
  assign wb.fwd_dat     = dat_q;

endmodule

// File: tb/tb_core_ex_wbck.sv
// Directed bench for core_ex_wbck: arbitration, starvation limit, x0, reset.
module tb_core_ex_wbck;
  logic clk = 1'b0;
  logic rst;
  int   pass_cnt = 0;
  int   total    = 0;

  always #5 clk = ~clk;

  core_ex_wbck_if #(.XLEN(32), .RFIDX_WIDTH(5)) bus ();

  core_ex_wbck #(.XLEN(32), .RFIDX_WIDTH(5), .STARVE_LIM(4)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (bus)
  );

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic drive_alu(input logic v, input logic [4:0] idx, input logic [31:0] dat);
    bus.alu_wbck_valid = v; bus.alu_wbck_idx = idx; bus.alu_wbck_dat = dat;
  endtask

  task automatic drive_lsu(input logic v, input logic [4:0] idx, input logic [31:0] dat);
    bus.lsu_wbck_valid = v; bus.lsu_wbck_idx = idx; bus.lsu_wbck_dat = dat;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive_alu(1'b0, 5'd0, 32'd0);
    drive_lsu(1'b0, 5'd0, 32'd0);
    tick; tick;
    total++; if (bus.wb_dest_wen !== 1'b0) $display("FAIL reset_wen got=%b exp=0", bus.wb_dest_wen); else pass_cnt++;
    total++; if (bus.wb_dest_idx !== 5'd0) $display("FAIL reset_idx got=%0d exp=0", bus.wb_dest_idx); else pass_cnt++;
    total++; if (bus.wb_dest_dat !== 32'd0) $display("FAIL reset_dat got=%h exp=0", bus.wb_dest_dat); else pass_cnt++;
    total++; if (dut.u_arb.starve_cnt_q !== 3'd0) $display("FAIL reset_cnt got=%0d exp=0", dut.u_arb.starve_cnt_q); else pass_cnt++;
    total++; if ({bus.alu_wbck_ready, bus.lsu_wbck_ready} !== 2'b11) $display("FAIL idle_ready got=%b exp=11", {bus.alu_wbck_ready, bus.lsu_wbck_ready}); else pass_cnt++;
    rst = 1'b0;
    tick;
  endtask

  task automatic test_alu_only;
    drive_alu(1'b1, 5'd5, 32'h1234_5678);
    #1;
    total++; if (bus.alu_wbck_ready !== 1'b1) $display("FAIL alu_only_ready got=%b exp=1", bus.alu_wbck_ready); else pass_cnt++;
    tick;
    drive_alu(1'b0, 5'd0, 32'd0);
    total++; if ({bus.wb_dest_wen, bus.wb_dest_idx, bus.wb_dest_dat} !== {1'b1, 5'd5, 32'h1234_5678})
      $display("FAIL alu_only_wb got=%b/%0d/%h exp=1/5/12345678", bus.wb_dest_wen, bus.wb_dest_idx, bus.wb_dest_dat); else pass_cnt++;
    tick;
    total++; if (bus.wb_dest_wen !== 1'b0) $display("FAIL alu_only_pulse got=%b exp=0", bus.wb_dest_wen); else pass_cnt++;
    total++; if (bus.wb_dest_idx !== 5'd5) $display("FAIL alu_only_hold_idx got=%0d exp=5", bus.wb_dest_idx); else pass_cnt++;
  endtask

  task automatic test_contested;
    drive_alu(1'b1, 5'd3, 32'hA);
    drive_lsu(1'b1, 5'd7, 32'hB);
    #1;
    total++; if ({bus.alu_wbck_ready, bus.lsu_wbck_ready} !== 2'b01) $display("FAIL contest_ready got=%b exp=01", {bus.alu_wbck_ready, bus.lsu_wbck_ready}); else pass_cnt++;
    tick;
    drive_lsu(1'b0, 5'd0, 32'd0);
    total++; if ({bus.wb_dest_wen, bus.wb_dest_idx, bus.wb_dest_dat} !== {1'b1, 5'd7, 32'hB})
      $display("FAIL contest_lsu_wb got=%b/%0d/%h exp=1/7/b", bus.wb_dest_wen, bus.wb_dest_idx, bus.wb_dest_dat); else pass_cnt++;
    #1;
    total++; if (bus.alu_wbck_ready !== 1'b1) $display("FAIL contest_alu_ready got=%b exp=1", bus.alu_wbck_ready); else pass_cnt++;
    tick;
    drive_alu(1'b0, 5'd0, 32'd0);
    total++; if ({bus.wb_dest_wen, bus.wb_dest_idx, bus.wb_dest_dat} !== {1'b1, 5'd3, 32'hA})
      $display("FAIL contest_alu_wb got=%b/%0d/%h exp=1/3/a", bus.wb_dest_wen, bus.wb_dest_idx, bus.wb_dest_dat); else pass_cnt++;
    tick;
  endtask

  task automatic test_starve;
    logic [9:0] exp_alu_win;
    logic [4:0] a_idx, l_idx, exp_idx;
    int         max_cnt;
    exp_alu_win = 10'b10_0001_0000;
    a_idx = 5'd20; l_idx = 5'd10; max_cnt = 0;
    drive_alu(1'b1, a_idx, {27'd0, a_idx});
    drive_lsu(1'b1, l_idx, {27'd0, l_idx});
    for (int i = 0; i < 10; i++) begin
      #1;
      total++; if ({bus.alu_wbck_ready, bus.lsu_wbck_ready} !== {exp_alu_win[i], ~exp_alu_win[i]})
        $display("FAIL starve_grant[%0d] got=%b exp=%b", i, {bus.alu_wbck_ready, bus.lsu_wbck_ready}, {exp_alu_win[i], ~exp_alu_win[i]}); else pass_cnt++;
      exp_idx = exp_alu_win[i] ? a_idx : l_idx;
      tick;
      total++; if ({bus.wb_dest_wen, bus.wb_dest_idx} !== {1'b1, exp_idx})
        $display("FAIL starve_wb[%0d] got=%b/%0d exp=1/%0d", i, bus.wb_dest_wen, bus.wb_dest_idx, exp_idx); else pass_cnt++;
      if (int'(dut.u_arb.starve_cnt_q) > max_cnt) max_cnt = int'(dut.u_arb.starve_cnt_q);
      if (exp_alu_win[i]) begin a_idx = a_idx + 5'd1; drive_alu(1'b1, a_idx, {27'd0, a_idx}); end
      else                begin l_idx = l_idx + 5'd1; drive_lsu(1'b1, l_idx, {27'd0, l_idx}); end
    end
    total++; if (max_cnt != 4) $display("FAIL starve_cnt_peak got=%0d exp=4", max_cnt); else pass_cnt++;
    drive_alu(1'b0, 5'd0, 32'd0);
    drive_lsu(1'b0, 5'd0, 32'd0);
    tick; tick;
  endtask

  task automatic test_x0;
    drive_lsu(1'b1, 5'd0, 32'hFFFF_FFFF);
    #1;
    total++; if (bus.lsu_wbck_ready !== 1'b1) $display("FAIL x0_ready got=%b exp=1", bus.lsu_wbck_ready); else pass_cnt++;
    tick;
    drive_lsu(1'b0, 5'd0, 32'd0);
    total++; if ({bus.wb_dest_wen, bus.fwd_valid} !== 2'b00) $display("FAIL x0_no_write got=%b exp=00", {bus.wb_dest_wen, bus.fwd_valid}); else pass_cnt++;
    total++; if ({bus.wb_dest_idx, bus.wb_dest_dat} !== {5'd0, 32'hFFFF_FFFF})
      $display("FAIL x0_capture got=%0d/%h exp=0/ffffffff", bus.wb_dest_idx, bus.wb_dest_dat); else pass_cnt++;
    tick;
  endtask

  task automatic test_reset_mid;
    drive_alu(1'b1, 5'd3, 32'h33);
    drive_lsu(1'b1, 5'd6, 32'h66);
    tick;
    drive_lsu(1'b0, 5'd0, 32'd0);
    drive_alu(1'b1, 5'd9, 32'h99);
    tick;
    rst = 1'b1;
    drive_alu(1'b1, 5'd4, 32'h44);
    #1;
    total++; if ({bus.wb_dest_wen, bus.wb_dest_idx} !== {1'b1, 5'd9}) $display("FAIL rstmid_pre got=%b/%0d exp=1/9", bus.wb_dest_wen, bus.wb_dest_idx); else pass_cnt++;
    total++; if (dut.u_arb.starve_cnt_q !== 3'd1) $display("FAIL rstmid_cnt_pre got=%0d exp=1", dut.u_arb.starve_cnt_q); else pass_cnt++;
    total++; if (bus.alu_wbck_ready !== 1'b1) $display("FAIL rstmid_ready got=%b exp=1", bus.alu_wbck_ready); else pass_cnt++;
    tick;
    rst = 1'b0;
    drive_alu(1'b0, 5'd0, 32'd0);
    total++; if ({bus.wb_dest_wen, bus.wb_dest_idx, bus.wb_dest_dat} !== {1'b0, 5'd0, 32'd0})
      $display("FAIL rstmid_post got=%b/%0d/%h exp=0/0/0", bus.wb_dest_wen, bus.wb_dest_idx, bus.wb_dest_dat); else pass_cnt++;
    total++; if (dut.u_arb.starve_cnt_q !== 3'd0) $display("FAIL rstmid_cnt got=%0d exp=0", dut.u_arb.starve_cnt_q); else pass_cnt++;
    tick;
    total++; if (bus.wb_dest_wen !== 1'b0) $display("FAIL rstmid_after got=%b exp=0", bus.wb_dest_wen); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    for (int i = 1; i <= 3; i++) begin
      drive_alu(1'b1, 5'(i), 32'(i * 17));
      tick;
      total++; if ({bus.wb_dest_wen, bus.wb_dest_idx, bus.wb_dest_dat} !== {1'b1, 5'(i), 32'(i * 17)})
        $display("FAIL b2b_wb[%0d] got=%b/%0d/%h exp=1/%0d/%h", i, bus.wb_dest_wen, bus.wb_dest_idx, bus.wb_dest_dat, i, i * 17); else pass_cnt++;
      total++; if ({bus.fwd_valid, bus.fwd_idx, bus.fwd_dat} !== {1'b1, 5'(i), 32'(i * 17)})
        $display("FAIL b2b_fwd[%0d] got=%b/%0d/%h exp=1/%0d/%h", i, bus.fwd_valid, bus.fwd_idx, bus.fwd_dat, i, i * 17); else pass_cnt++;
    end
    drive_alu(1'b0, 5'd0, 32'd0);
    tick;
    total++; if ({bus.wb_dest_wen, bus.fwd_valid} !== 2'b00) $display("FAIL b2b_end got=%b exp=00", {bus.wb_dest_wen, bus.fwd_valid}); else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_alu_only;
    test_contested;
    test_starve;
    test_x0;
    test_reset_mid;
    test_back_to_back;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
